// File: rtl/redux_mc.sv
// Multi-cycle 8-bit-instruction accumulator core: FETCH -> EXEC -> (MEM) -> FETCH,
// four DATA_W registers, request/acknowledge instruction and data ports.
module redux_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic              halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_BRZR = 4'h0;
  localparam logic [3:0] OP_JI   = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_SLR  = 4'hB;
  localparam logic [3:0] OP_SRR  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Register values used as addresses are truncated or zero-extended to ADDR_W.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    logic [31:0] wide;
    wide = 32'(v);
    return wide[ADDR_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sext_data(input logic [3:0] imm);
    return DATA_W'(signed'(imm));
  endfunction

  function automatic logic signed [ADDR_W-1:0] sext_addr(input logic [3:0] imm);
    return ADDR_W'(signed'(imm));
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [DATA_W-1:0] regs [4];

  logic [3:0]        opcode;
  logic [1:0]        ra;
  logic [1:0]        rb;
  logic [DATA_W-1:0] rav;
  logic [DATA_W-1:0] rbv;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_mem_op;

  assign opcode    = ir[7:4];
  assign ra        = ir[3:2];
  assign rb        = ir[1:0];
  assign rav       = regs[ra];
  assign rbv       = regs[rb];
  assign pc_inc    = pc + ADDR_W'(1);
  assign is_mem_op = (opcode == OP_LD) || (opcode == OP_ST);

  always_comb begin
    alu_res = rav;
    case (opcode)
      OP_NOT:  alu_res = ~rbv;
      OP_ADD:  alu_res = rav + rbv;
      OP_SUB:  alu_res = rav - rbv;
      OP_AND:  alu_res = rav & rbv;
      OP_OR:   alu_res = rav | rbv;
      OP_XOR:  alu_res = rav ^ rbv;
      OP_SLR:  alu_res = rav << rbv[2:0];
      OP_SRR:  alu_res = rav >> rbv[2:0];
      default: alu_res = rav;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          pc    <= pc_inc;
          case (opcode)
            OP_BRZR: pc <= (rav == '0) ? to_addr(rbv) : pc_inc;
            OP_JI:   pc <= pc + sext_addr(ir[3:0]);
            OP_LD, OP_ST: begin
              pc    <= pc;
              state <= S_MEM;
            end
            OP_ADDI: regs[0] <= regs[0] + sext_data(ir[3:0]);
            OP_NOT, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLR, OP_SRR:
              regs[ra] <= alu_res;
            OP_HALT: begin
              pc    <= pc;
              state <= S_HALT;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (opcode == OP_LD) regs[ra] <= dmem_rdata;
            pc    <= pc_inc;
            state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (state == S_MEM) && (opcode == OP_ST);
  assign dmem_addr  = to_addr(rbv);
  assign dmem_wdata = rav;
  assign halted     = (state == S_HALT);

  // A completion that coincides with reset is abandoned, so it does not retire.
  always_comb begin
    retire = 1'b0;
    if (!rst) begin
      if (state == S_EXEC) retire = !is_mem_op;
      else if (state == S_MEM) retire = dmem_ack;
    end
  end

endmodule

// File: tb/tb_redux_mc.sv
// Bench for redux_mc: small programs run against wait-state memory models, stores
// checked against a queue of expected (address, data) pairs.
module tb_redux_mc;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [7:0]        imem_rdata = 8'h00;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack = 1'b0;
  logic [DATA_W-1:0] dmem_rdata = '0;
  logic              retire;
  logic              halted;

  logic [7:0]        imem [256];
  logic [DATA_W-1:0] dmem [256];
  logic [7:0]        prog [$];
  st_t               exp_q [$];

  int total = 0;
  int bad = 0;
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;
  int st_len = 0;
  int last_st_len = 0;
  int ret_cnt = 0;
  int last_cyc = 0;

  always #5 clk = ~clk;

  redux_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responders: ack after the configured number of wait cycles.
  always @(negedge clk) begin
    st_t e;
    if (retire === 1'b1) ret_cnt++;
    if (imem_req === 1'b1) begin
      if (icnt >= imem_wait) begin
        imem_ack = 1'b1;
        imem_rdata = imem[imem_addr];
      end else imem_ack = 1'b0;
      icnt++;
    end else begin
      imem_ack = 1'b0;
      icnt = 0;
    end
    if (dmem_req === 1'b1) begin
      if (dmem_we) st_len++;
      if (dcnt >= dmem_wait) begin
        dmem_ack = 1'b1;
        dmem_rdata = dmem[dmem_addr];
        if (dmem_we) begin
          last_st_len = st_len;
          st_len = 0;
          if (exp_q.size() == 0) chk("st_extra", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            chk("st_addr", 32'(dmem_addr), 32'(e.addr));
            chk("st_data", 32'(dmem_wdata), 32'(e.data));
          end
          dmem[dmem_addr] = dmem_wdata;
        end
      end else dmem_ack = 1'b0;
      dcnt++;
    end else begin
      dmem_ack = 1'b0;
      dcnt = 0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'hF0;
      dmem[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    ret_cnt = 0;
    st_len = 0;
  endtask

  task automatic wait_halt(input string name, input int max_cyc, input logic [ADDR_W-1:0] halt_pc);
    int cyc;
    cyc = 0;
    while (halted !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    last_cyc = cyc;
    chk({name, "_halted"}, 32'(halted), 32'd1);
    chk({name, "_pc"}, 32'(imem_addr), 32'(halt_pc));
    chk({name, "_stores_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run(input string name, input int max_cyc, input logic [ADDR_W-1:0] halt_pc);
    load_prog();
    do_reset();
    wait_halt(name, max_cyc, halt_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // addi 3; addi -1; halt with zero-wait memories
    clear_mem();
    imem_wait = 0; dmem_wait = 0;
    prog = '{8'h43, 8'h4F, 8'hF0};
    run("s1", 50, 8'h02);
    chk("s1_cycle", 32'(last_cyc), 32'd6);
    chk("s1_retires", 32'(ret_cnt), 32'd3);
    repeat (3) @(negedge clk);
    chk("s1_frozen_halted", 32'(halted), 32'd1);
    chk("s1_frozen_ireq", 32'(imem_req), 32'd0);
    chk("s1_frozen_dreq", 32'(dmem_req), 32'd0);
    chk("s1_frozen_pc", 32'(imem_addr), 32'h02);
    chk("s1_frozen_retires", 32'(ret_cnt), 32'd3);

    // Same arithmetic, R0 observed through a store, with wait states
    clear_mem();
    imem_wait = 1; dmem_wait = 1;
    prog = '{8'h43, 8'h4F, 8'h31, 8'hF0};
    exp_q.push_back(st_t'{8'h00, 16'h0002});
    run("s1b", 100, 8'h03);

    // st R1,[R2] with a 3-cycle delayed ack
    clear_mem();
    imem_wait = 0; dmem_wait = 3;
    dmem[0] = 16'h0005; dmem[1] = 16'h0020;
    prog = '{8'h24, 8'h41, 8'h28, 8'h36, 8'hF0};
    exp_q.push_back(st_t'{8'h20, 16'h0005});
    run("s2", 100, 8'h04);
    chk("s2_req_len", 32'(last_st_len), 32'd4);

    // brzr taken, not taken, and a nonzero value with a zero low byte
    clear_mem();
    imem_wait = 0; dmem_wait = 0;
    dmem[0] = 16'h0010;
    prog = '{8'h24, 8'h01};
    run("s3a", 50, 8'h10);
    prog = '{8'h24, 8'h41, 8'h01};
    run("s3b", 50, 8'h03);
    dmem[1] = 16'h0100;
    prog = '{8'h24, 8'h41, 8'h20, 8'h01};
    run("s3c", 50, 8'h04);

    // ji -4 from PC=2 wraps to 0xFE, then ji +7 wraps to 0x05
    clear_mem();
    prog = '{8'hD0, 8'hD0, 8'h1C};
    imem[8'hFE] = 8'h17;
    run("s4", 50, 8'h05);
    chk("s4_cycle", 32'(last_cyc), 32'd10);
    chk("s4_retires", 32'(ret_cnt), 32'd5);

    // 16-bit wrap on add and shift amount taken from the low three bits
    clear_mem();
    dmem[0] = 16'hFFFF; dmem[1] = 16'h0009;
    prog = '{8'h24, 8'h65, 8'h34, 8'h41, 8'h28, 8'hB6, 8'h34, 8'hF0};
    exp_q.push_back(st_t'{8'h00, 16'hFFFE});
    exp_q.push_back(st_t'{8'h01, 16'hFFFC});
    run("s5", 100, 8'h07);

    // Logic and arithmetic mix with slow instruction memory
    clear_mem();
    imem_wait = 2; dmem_wait = 1;
    dmem[0] = 16'h00F0; dmem[1] = 16'h0F3C; dmem[2] = 16'h0003;
    prog = '{8'h24, 8'h41, 8'h28, 8'h41, 8'h2C, 8'h4E,
             8'h96, 8'h34, 8'hA6, 8'h41, 8'h34,
             8'h76, 8'h41, 8'h34, 8'hC7, 8'h41, 8'h34,
             8'h86, 8'h41, 8'h34, 8'h5B, 8'h41, 8'h38, 8'hF0};
    exp_q.push_back(st_t'{8'h00, 16'h0FFC});
    exp_q.push_back(st_t'{8'h01, 16'h00C0});
    exp_q.push_back(st_t'{8'h02, 16'hF184});
    exp_q.push_back(st_t'{8'h03, 16'h1E30});
    exp_q.push_back(st_t'{8'h04, 16'h0E30});
    exp_q.push_back(st_t'{8'h05, 16'hFFFC});
    run("s6", 600, 8'h17);

    // Reset arriving together with the ack of a pending load
    clear_mem();
    imem_wait = 0; dmem_wait = 2;
    dmem[0] = 16'h0055;
    prog = '{8'h24};
    load_prog();
    do_reset();
    for (int i = 0; i < 20 && dmem_req !== 1'b1; i++) @(negedge clk);
    chk("s7_dreq", 32'(dmem_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    imem[0] = 8'h34;
    imem[1] = 8'hF0;
    @(negedge clk);
    chk("s7_ireq", 32'(imem_req), 32'd1);
    chk("s7_iaddr", 32'(imem_addr), 32'd0);
    chk("s7_dreq_off", 32'(dmem_req), 32'd0);
    rst = 1'b0;
    dmem_wait = 0;
    exp_q.push_back(st_t'{8'h00, 16'h0000});
    wait_halt("s7", 50, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/redux_mc.md
REDUX_MC -- requirements
Module: redux_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register/ALU/data width (range 8..32).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning PC and memory address width (range 4..16).
REQ-003 SHALL have these ports:
  - clk  in  1  single clock, all state updates on its rising edge.
  - rst  in  1  reset, synchronous and active-high.
  - imem_req  out  1  instruction fetch request.
  - imem_addr  out  ADDR_W  fetch address, equal to PC.
  - imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
  - imem_rdata  in  8  instruction word.
  - dmem_req  out  1  data access request.
  - dmem_we  out  1  1 = store, 0 = load.
  - dmem_addr  out  ADDR_W  data address.
  - dmem_wdata  out  DATA_W  store data.
  - dmem_ack  in  1  data access complete; dmem_rdata valid in the same cycle for loads.
  - dmem_rdata  in  DATA_W  load data.
  - retire  out  1  one-cycle pulse per completed instruction.
  - halted  out  1  core stopped by a halt instruction.

Function
REQ-004 Instruction fields SHALL be: opcode = [7:4], imm = [3:0], ra = [3:2], rb = [1:0]; sext(imm) SHALL sign-extend imm to the target width.
REQ-005 The register file SHALL hold 4 registers R0..R3 of DATA_W bits; R0 SHALL be writable.
REQ-006 Opcodes SHALL be:
  - 0 brzr: if R[ra]==0 then PC=R[rb], else PC+1.
  - 1 ji: PC=PC+sext(imm).
  - 2 ld: R[ra]=M[R[rb]].
  - 3 st: M[R[rb]]=R[ra].
  - 4 addi: R0=R0+sext(imm).
  - 5 not: R[ra]=~R[rb].
  - 6 add: R[ra]=R[ra]+R[rb].
  - 7 sub: R[ra]=R[ra]-R[rb].
  - 8 and: R[ra]=R[ra]&R[rb].
  - 9 or: R[ra]=R[ra]|R[rb].
  - A xor: R[ra]=R[ra]^R[rb].
  - B slr: R[ra]=R[ra]<<R[rb][2:0].
  - C srr: R[ra]=R[ra]>>R[rb][2:0], logical.
  - D, E nop.
  - F halt.
REQ-007 All arithmetic SHALL wrap modulo 2^DATA_W; PC arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-008 Register-to-address use (dmem_addr, brzr target) SHALL truncate a wider register or zero-extend a narrower one to ADDR_W.
REQ-009 PC SHALL be PC+1 after every instruction except taken brzr, ji and halt.
REQ-010 FSM states SHALL be FETCH, EXEC, MEM, HALT.
REQ-011 FETCH: imem_req=1 with imem_addr=PC; on a cycle with imem_ack=1, IR SHALL latch imem_rdata and the next state SHALL be EXEC.
REQ-012 EXEC (one cycle): for ALU, addi, branch and nop the core SHALL write the register and/or PC, pulse retire, and go to FETCH; ld/st SHALL go to MEM; halt SHALL pulse retire and go to HALT.
REQ-013 MEM: dmem_req=1 with dmem_addr/dmem_we/dmem_wdata held stable; on dmem_ack=1 the core SHALL write R[ra]=dmem_rdata for ld, update PC, pulse retire, and go to FETCH.
REQ-014 Requests SHALL stay asserted with stable address/data until acknowledged; the core SHALL ignore ack in any cycle where the corresponding req is 0.
REQ-015 Minimum latency SHALL be 2 cycles per non-memory instruction and 3 per ld/st, given zero-wait ack; each wait cycle SHALL add one cycle.
REQ-016 imem_req and dmem_req SHALL never be asserted in the same cycle.
REQ-017 HALT SHALL hold halted=1, both reqs 0 and all state frozen until rst.
REQ-018 The brzr zero test SHALL use the full DATA_W value of R[ra].

Reset
REQ-019 At a rising edge with rst=1, the core SHALL set PC=0, R0..R3=0, IR=0 and state=FETCH.
REQ-020 Outputs in the cycle following a reset edge SHALL be imem_req=1, imem_addr=0, dmem_req=0, dmem_we=0, retire=0, halted=0.
REQ-021 Reset SHALL take priority over any ack or instruction in progress; an interrupted transaction SHALL be abandoned with no register, PC or memory side effect committed in that cycle.

Verification
REQ-022 The bench SHALL cover these scenarios:
  - reset, zero-wait memories, program addi 3; addi -1; halt (0x43, 0x4F, 0xF0) -> R0=2, halted=1 at cycle 6, 3 retire pulses.
  - R1=5, R2=0x20, st R1,R2 (0x36), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_addr=0x20, dmem_wdata=5, we=1, PC=1 after.
  - R0=0, R1=0x10, brzr R0,R1 -> PC=0x10; repeat with R0=1 -> PC=1.
  - PC=0x02, ji -4 (0x1C) with ADDR_W=8 -> PC=0xFE (wrap).
  - DATA_W=16, R1=0xFFFF, add R1,R1 -> 0xFFFE; slr with R2=9 -> shift by 1.
  - rst asserted while in MEM with ld pending -> R[ra] unchanged (0), next cycle imem_req=1, imem_addr=0.
